// File: rtl/cmd_queue_loader.sv
// Assembles NSEG host stream segments into one command word and pushes each
// word into a command fifo, for a session of i_total_cmds commands.
module cmd_queue_loader #(
   parameter int CMD_WIDTH = 64,
   parameter int SEG_WIDTH = 32,
   parameter int CNT_WIDTH = 32
) (
   input  logic                 i_clk,
   input  logic                 i_rstn,
   input  logic                 i_start,
   input  logic [CNT_WIDTH-1:0] i_total_cmds,
   input  logic                 i_seg_valid,
   input  logic [SEG_WIDTH-1:0] i_seg_data,
   output logic                 o_seg_ready,
   input  logic                 i_fifo_full,
   output logic                 o_fifo_write,
   output logic [CMD_WIDTH-1:0] o_fifo_data,
   output logic                 o_busy,
   output logic                 o_done,
   output logic [CNT_WIDTH-1:0] o_cmd_count
);
   localparam int NSEG  = (CMD_WIDTH + SEG_WIDTH - 1) / SEG_WIDTH;
   localparam int IDX_W = (NSEG > 1) ? $clog2(NSEG) : 1;
   localparam int ASM_W = NSEG * SEG_WIDTH;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSEG - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ASSEMBLE,
      S_PUSH,
      S_DONE
   } state_t;

   state_t               state_q, state_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [CMD_WIDTH-1:0] asm_q, asm_d;
   logic [CNT_WIDTH-1:0] total_q, total_d;
   logic [CNT_WIDTH-1:0] count_q, count_d;
   logic [ASM_W-1:0]     asm_ext;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      asm_d   = asm_q;
      total_d = total_q;
      count_d = count_q;
      // Work in a segment-aligned view so the last segment's excess bits fall off on truncation.
      asm_ext = ASM_W'(asm_q);
      case (state_q)
         S_IDLE, S_DONE: begin
            if (i_start) begin
               total_d = i_total_cmds;
               count_d = '0;
               idx_d   = '0;
               state_d = (i_total_cmds == '0) ? S_DONE : S_ASSEMBLE;
            end
         end
         S_ASSEMBLE: begin
            if (i_seg_valid) begin
               for (int k = 0; k < NSEG; k++) begin
                  if (idx_q == IDX_W'(k)) asm_ext[k*SEG_WIDTH +: SEG_WIDTH] = i_seg_data;
               end
               asm_d = asm_ext[CMD_WIDTH-1:0];
               if (idx_q == LAST_IDX) begin
                  idx_d   = '0;
                  state_d = S_PUSH;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         S_PUSH: begin
            if (!i_fifo_full) begin
               count_d = count_q + CNT_WIDTH'(1);
               state_d = (count_d == total_q) ? S_DONE : S_ASSEMBLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         asm_q   <= '0;
         total_q <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         asm_q   <= asm_d;
         total_q <= total_d;
         count_q <= count_d;
      end
   end

   // The assembly register is only written in ASSEMBLE, so the word holds steady through PUSH.
   assign o_seg_ready  = (state_q == S_ASSEMBLE);
   assign o_fifo_write = (state_q == S_PUSH) && !i_fifo_full;
   assign o_fifo_data  = asm_q;
   assign o_busy       = (state_q == S_ASSEMBLE) || (state_q == S_PUSH);
   assign o_done       = (state_q == S_DONE);
   assign o_cmd_count  = count_q;

endmodule

// File: tb/tb_cmd_queue_loader.sv
// Randomized bench for cmd_queue_loader; a transaction-level model of the
// session (segments collected, word pending, commands written) is compared every cycle.
module tb_cmd_queue_loader;
   localparam int CMD_WIDTH = 64;
   localparam int SEG_WIDTH = 32;
   localparam int CNT_WIDTH = 32;
   localparam int NSEG      = (CMD_WIDTH + SEG_WIDTH - 1) / SEG_WIDTH;

   logic                 clk       = 1'b0;
   logic                 rstn      = 1'b1;
   logic                 start     = 1'b0;
   logic [CNT_WIDTH-1:0] total     = '0;
   logic                 seg_valid = 1'b0;
   logic [SEG_WIDTH-1:0] seg_data  = '0;
   logic                 fifo_full = 1'b0;
   logic                 seg_ready;
   logic                 fifo_write;
   logic [CMD_WIDTH-1:0] fifo_data;
   logic                 busy;
   logic                 done;
   logic [CNT_WIDTH-1:0] cmd_count;

   cmd_queue_loader #(
      .CMD_WIDTH(CMD_WIDTH),
      .SEG_WIDTH(SEG_WIDTH),
      .CNT_WIDTH(CNT_WIDTH)
   ) dut (
      .i_clk       (clk),
      .i_rstn      (rstn),
      .i_start     (start),
      .i_total_cmds(total),
      .i_seg_valid (seg_valid),
      .i_seg_data  (seg_data),
      .o_seg_ready (seg_ready),
      .i_fifo_full (fifo_full),
      .o_fifo_write(fifo_write),
      .o_fifo_data (fifo_data),
      .o_busy      (busy),
      .o_done      (done),
      .o_cmd_count (cmd_count)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Session model: active/done flags, segments gathered for the current
   // command, and whether a complete word is waiting for the fifo.
   bit                   m_active;
   bit                   m_have;
   bit                   m_done;
   int                   m_nseg;
   logic [SEG_WIDTH-1:0] m_buf [NSEG];
   logic [CMD_WIDTH-1:0] m_word;
   logic [CNT_WIDTH-1:0] m_total;
   logic [CNT_WIDTH-1:0] m_count;
   int                   m_xfers;
   int                   d_xfers;
   logic [CMD_WIDTH-1:0] exp_q[$];
   logic [CMD_WIDTH-1:0] got_q[$];

   function automatic logic [CMD_WIDTH-1:0] pack_word();
      logic [NSEG*SEG_WIDTH-1:0] w;
      w = '0;
      for (int k = 0; k < NSEG; k++) w[k*SEG_WIDTH +: SEG_WIDTH] = m_buf[k];
      return w[CMD_WIDTH-1:0];
   endfunction

   task automatic model_reset();
      m_active = 0;
      m_have   = 0;
      m_done   = 0;
      m_nseg   = 0;
      m_word   = '0;
      m_total  = '0;
      m_count  = '0;
   endtask

   task automatic model_step();
      if (!m_active) begin
         if (start) begin
            m_total  = total;
            m_count  = '0;
            m_nseg   = 0;
            m_done   = (total == '0);
            m_active = (total != '0);
         end
      end else if (!m_have) begin
         if (seg_valid) begin
            m_buf[m_nseg] = seg_data;
            m_nseg++;
            m_xfers++;
            if (m_nseg == NSEG) begin
               m_word = pack_word();
               m_have = 1;
               m_nseg = 0;
            end
         end
      end else if (!fifo_full) begin
         m_have  = 0;
         m_count = m_count + 1;
         exp_q.push_back(m_word);
         if (m_count == m_total) begin
            m_active = 0;
            m_done   = 1;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (rstn) model_step();
      #1;
   endtask

   task automatic start_sess(input logic [CNT_WIDTH-1:0] t);
      exp_q.delete();
      got_q.delete();
      m_xfers = 0;
      d_xfers = 0;
      start   = 1'b1;
      total   = t;
      tick();
      start   = 1'b0;
   endtask

   task automatic cmp_queues(input string tag);
      chk({tag, "_nwr"}, 64'(got_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         chk({tag, "_wr"}, 64'(got_q[i]), 64'(exp_q[i]));
      chk({tag, "_xfers"}, 64'(d_xfers), 64'(m_xfers));
   endtask

   task automatic wait_done(input int budget, input int full_pct, input bit rand_start, input string tag);
      int n;
      n = 0;
      while (!done && n < budget) begin
         seg_valid = 1'($urandom_range(0, 1));
         seg_data  = $urandom;
         fifo_full = ($urandom_range(0, 99) < full_pct);
         if (rand_start && $urandom_range(0, 9) == 0) begin
            start = 1'b1;
            total = CNT_WIDTH'($urandom_range(0, 9));
         end
         tick();
         start = 1'b0;
         n++;
      end
      seg_valid = 1'b0;
      fifo_full = 1'b0;
      chk({tag, "_done"}, 64'(done), 64'(1));
   endtask

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      chk("seg_ready", 64'(seg_ready), 64'(m_active && !m_have));
      chk("fifo_write", 64'(fifo_write), 64'(m_active && m_have && !fifo_full));
      chk("busy", 64'(busy), 64'(m_active));
      chk("done", 64'(done), 64'(m_done));
      chk("cmd_count", 64'(cmd_count), 64'(m_count));
      if (m_have) chk("fifo_data", 64'(fifo_data), 64'(m_word));
      if (fifo_write) got_q.push_back(fifo_data);
      if (seg_valid && seg_ready) d_xfers++;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [SEG_WIDTH-1:0] a, b;
      model_reset();
      #1 rstn = 1'b0;
      tick();
      tick();
      chk("rst_data", 64'(fifo_data), 64'h0);
      chk("rst_count", 64'(cmd_count), 64'h0);
      chk("rst_ready", 64'(seg_ready), 64'h0);
      chk("rst_busy", 64'(busy), 64'h0);
      rstn = 1'b1;
      tick();

      // Three commands of 0x22222222_11111111 with valid held high.
      start_sess(3);
      for (int i = 1; i <= 9; i++) begin
         seg_valid = 1'b1;
         seg_data  = (i % 3 == 1) ? 32'h11111111 : (i % 3 == 2) ? 32'h22222222 : 32'h33333333;
         tick();
         if (i == 8) chk("basic_done_e8", 64'(done), 64'h0);
      end
      seg_valid = 1'b0;
      chk("basic_done_e9", 64'(done), 64'h1);
      chk("basic_count", 64'(cmd_count), 64'h3);
      chk("basic_nwr", 64'(got_q.size()), 64'h3);
      for (int i = 0; i < got_q.size(); i++) chk("basic_word", got_q[i], 64'h2222222211111111);
      chk("basic_xfers", 64'(d_xfers), 64'h6);

      // Zero-length session.
      start_sess(0);
      chk("zero_done", 64'(done), 64'h1);
      chk("zero_busy", 64'(busy), 64'h0);
      chk("zero_count", 64'(cmd_count), 64'h0);
      seg_valid = 1'b1;
      repeat (3) tick();
      seg_valid = 1'b0;
      chk("zero_nwr", 64'(got_q.size()), 64'h0);
      chk("zero_xfers", 64'(d_xfers), 64'h0);

      // Fifo full for five cycles while a word waits.
      a = 32'hA5A50001;
      b = 32'h5A5A0002;
      start_sess(1);
      seg_valid = 1'b1;
      seg_data  = a;
      tick();
      seg_data  = b;
      tick();
      fifo_full = 1'b1;
      seg_data  = 32'hDEADBEEF;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("full_write", 64'(fifo_write), 64'h0);
         chk("full_ready", 64'(seg_ready), 64'h0);
         chk("full_data", fifo_data, 64'h5A5A0002A5A50001);
         tick();
      end
      fifo_full = 1'b0;
      #1;
      chk("full_release_write", 64'(fifo_write), 64'h1);
      tick();
      seg_valid = 1'b0;
      chk("full_done", 64'(done), 64'h1);
      chk("full_nwr", 64'(got_q.size()), 64'h1);
      if (got_q.size() > 0) chk("full_word", got_q[0], 64'h5A5A0002A5A50001);

      // Random valid, four commands.
      start_sess(4);
      wait_done(200, 0, 0, "rand4");
      chk("rand4_count", 64'(cmd_count), 64'h4);
      chk("rand4_xfers_lit", 64'(d_xfers), 64'h8);
      cmp_queues("rand4");

      // i_start during ASSEMBLE is ignored.
      start_sess(2);
      seg_valid = 1'b1;
      seg_data  = $urandom;
      tick();
      start = 1'b1;
      total = 7;
      tick();
      start = 1'b0;
      wait_done(100, 0, 0, "restart");
      chk("restart_count", 64'(cmd_count), 64'h2);
      cmp_queues("restart");

      // Reset after first segment of the second command.
      start_sess(3);
      seg_valid = 1'b1;
      repeat (4) begin
         seg_data = $urandom;
         tick();
      end
      rstn = 1'b0;
      model_reset();
      #1;
      chk("mid_rst_ready", 64'(seg_ready), 64'h0);
      chk("mid_rst_write", 64'(fifo_write), 64'h0);
      chk("mid_rst_data", 64'(fifo_data), 64'h0);
      chk("mid_rst_busy", 64'(busy), 64'h0);
      chk("mid_rst_count", 64'(cmd_count), 64'h0);
      tick();
      tick();
      rstn = 1'b1;
      #1;
      chk("post_rst_write", 64'(fifo_write), 64'h0);
      tick();
      seg_valid = 1'b0;
      start_sess(1);
      seg_valid = 1'b1;
      seg_data  = 32'hC0C0C0C0;
      tick();
      seg_data  = 32'hD0D0D0D0;
      tick();
      seg_valid = 1'b0;
      tick();
      chk("new_done", 64'(done), 64'h1);
      chk("new_nwr", 64'(got_q.size()), 64'h1);
      if (got_q.size() > 0) chk("new_word", got_q[0], 64'hD0D0D0D0C0C0C0C0);

      // Maximum total does not end the session early.
      start_sess('1);
      for (int n = 0; n < 100 && cmd_count != 2; n++) begin
         seg_valid = 1'b1;
         seg_data  = $urandom;
         tick();
      end
      seg_valid = 1'b0;
      chk("max_count", 64'(cmd_count), 64'h2);
      chk("max_busy", 64'(busy), 64'h1);
      chk("max_done", 64'(done), 64'h0);
      rstn = 1'b0;
      model_reset();
      tick();
      rstn = 1'b1;
      tick();

      // Random sessions with backpressure and stray start pulses.
      for (int s = 0; s < 8; s++) begin
         start_sess(CNT_WIDTH'($urandom_range(1, 5)));
         wait_done(400, 30, 1, "rsess");
         chk("rsess_count", 64'(cmd_count), 64'(m_total));
         cmp_queues("rsess");
      end

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule

// File: doc/cmd_queue_loader.md
CMD_QUEUE_LOADER -- requirements
Module: cmd_queue_loader

Interface
REQ-001 Parameter CMD_WIDTH, default 64, width of one assembled command word (cmd_t).
REQ-002 Parameter SEG_WIDTH, default 32, width of one input stream segment; NSEG = ceil(CMD_WIDTH/SEG_WIDTH).
REQ-003 Parameter CNT_WIDTH, default 32, width of command counters.
REQ-004 One clock, i_clk; reset is i_rstn, asynchronous, active-low.
REQ-005 i_clk  input  1  clock, all state on rising edge.
REQ-006 i_rstn  input  1  asynchronous active-low reset.
REQ-007 i_start  input  1  one-cycle pulse, begins a load session.
REQ-008 i_total_cmds  input  CNT_WIDTH  number of commands in session, sampled when i_start is accepted.
REQ-009 i_seg_valid  input  1  segment valid from host stream.
REQ-010 i_seg_data  input  SEG_WIDTH  segment payload.
REQ-011 o_seg_ready  output  1  loader accepts segment this cycle.
REQ-012 i_fifo_full  input  1  command fifo cannot accept a write.
REQ-013 o_fifo_write  output  1  write strobe to command fifo i_write.
REQ-014 o_fifo_data  output  CMD_WIDTH  command word to command fifo i_data.
REQ-015 o_busy  output  1  session in progress.
REQ-016 o_done  output  1  session complete, held until next accepted i_start.
REQ-017 o_cmd_count  output  CNT_WIDTH  commands written in current session.

Function
REQ-018 FSM states IDLE, ASSEMBLE, PUSH, DONE; one state per cycle, registered.
REQ-019 i_start is accepted only in IDLE or DONE; ignored in ASSEMBLE and PUSH.
REQ-020 On accepted i_start: latch i_total_cmds, clear o_cmd_count, segment index and o_done; next state ASSEMBLE, or DONE if i_total_cmds == 0.
REQ-021 o_seg_ready = 1 exactly when state is ASSEMBLE; a segment transfers on a cycle with i_seg_valid && o_seg_ready.
REQ-022 Segment k (k = 0..NSEG-1) of a command lands in bits [k*SEG_WIDTH +: SEG_WIDTH] of the assembly register; segment 0 is least significant.
REQ-023 Bits of the last segment beyond CMD_WIDTH are discarded.
REQ-024 Transfer of segment NSEG-1 moves the FSM to PUSH and resets segment index to 0; otherwise index increments and state stays ASSEMBLE.
REQ-025 In PUSH, o_fifo_write = !i_fifo_full (combinational on i_fifo_full); o_fifo_data equals the assembled word and is stable throughout PUSH.
REQ-026 Latency: last segment transferred on edge N -> o_fifo_write may assert in cycle N+1; with full low, write completes on edge N+1.
REQ-027 PUSH persists while i_fifo_full = 1; no data loss, no extra segments accepted.
REQ-028 On a completed write, o_cmd_count increments by 1; if new count equals latched total, next state DONE, else ASSEMBLE.
REQ-029 o_fifo_write is never asserted outside PUSH and at most once per command.
REQ-030 o_busy = 1 in ASSEMBLE and PUSH; o_done = 1 in DONE only.
REQ-031 Counter arithmetic is unsigned, CNT_WIDTH bits; total of 2^CNT_WIDTH-1 supported without wrap.
REQ-032 i_seg_valid asserted in IDLE, PUSH or DONE is ignored (no transfer, data not captured).
REQ-033 Throughput: with valid always high and fifo never full, one command per NSEG+1 cycles.

Reset
REQ-034 i_rstn low, at any time incl. mid-session: state IDLE, o_seg_ready 0, o_fifo_write 0, o_fifo_data 0, o_busy 0, o_done 0, o_cmd_count 0, segment index 0, latched total 0.
REQ-035 A partially assembled command at reset is discarded; no write occurs in the reset cycle or the first cycle after release.

Verification
REQ-036 Defaults, i_start with total=3, segments 0x11111111,0x22222222 per cmd, full=0 -> three writes of 0x2222222211111111, o_cmd_count=3, o_done=1 on 9th cycle after start.
REQ-037 total=0 -> DONE one cycle after start, no o_seg_ready, no write, o_done=1.
REQ-038 i_fifo_full=1 for 5 cycles at PUSH -> o_fifo_write 0 for 5 cycles, o_seg_ready 0, then single write with unchanged data.
REQ-039 i_seg_valid toggled randomly, total=4 -> exactly 8 segment transfers, 4 writes, data in order.
REQ-040 Reset asserted after first segment of second command -> all outputs zero, o_cmd_count 0; new start total=1 writes only new data.
REQ-041 i_start pulsed during ASSEMBLE -> ignored; session completes with original total.
